regfile_mp: RTL and testbench

- Parametrised multi-port integer register file with N_WR write ports and N_RD synchronous read ports.
- Provides same-cycle write-to-read forwarding and an optional hard-wired zero register.
- Adds a per-register busy scoreboard so issue logic can detect pending writebacks.
- Sits between decode/issue (read ports, scoreboard set) and writeback (write ports) in the core pipeline.

---
 rtl/regfile_mp_if.sv | 31 +++
 rtl/regfile_mp.sv | 86 ++++++++
 tb/tb_regfile_mp.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write, read and scoreboard signals between the pipeline and regfile_mp
interface regfile_mp_if #(
  parameter int N_REGS = 32,
  parameter int R_WIDTH = 32,
  parameter int N_RD = 2,
  parameter int N_WR = 1
);
  localparam int W_ADDR = $clog2(N_REGS);
  logic [N_WR-1:0]         wr_en;
  logic [N_WR*W_ADDR-1:0]  wr_addr;
  logic [N_WR*R_WIDTH-1:0] wr_data;
  logic [N_WR-1:0]         wr_addr_error;
  logic                    wr_collision;
  logic [N_RD-1:0]         rd_en;
  logic [N_RD*W_ADDR-1:0]  rd_addr;
  logic [N_RD*R_WIDTH-1:0] rd_data;
  logic [N_RD-1:0]         rd_valid;
  logic [N_RD-1:0]         rd_busy;
  logic [N_RD-1:0]         rd_addr_error;
  logic                    sb_set;
  logic [W_ADDR-1:0]       sb_addr;
  logic [N_REGS-1:0]       busy_vec;
  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, sb_set, sb_addr,
    input  wr_addr_error, wr_collision, rd_data, rd_valid, rd_busy, rd_addr_error, busy_vec
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, sb_set, sb_addr,
    output wr_addr_error, wr_collision, rd_data, rd_valid, rd_busy, rd_addr_error, busy_vec
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-to-read forwarding, zero register and busy scoreboard
module regfile_mp #(
  parameter int N_REGS = 32,
  parameter int R_WIDTH = 32,
  parameter int N_RD = 2,
  parameter int N_WR = 1,
  parameter int ZERO_REG = 1
) (
  input logic clk,
  input logic rst,
  regfile_mp_if.slave bus
);
  localparam int W_ADDR = $clog2(N_REGS);
  logic [R_WIDTH-1:0]      r_regs [N_REGS];
  logic [R_WIDTH-1:0]      w_wd [N_REGS];
  logic [N_REGS-1:0]       r_busy, w_we, w_busy_next;
  logic [N_WR-1:0]         w_wvalid, r_wr_err;
  logic                    w_coll, r_coll;
  logic [N_RD-1:0]         w_rvalid, w_rbusy, r_rd_valid, r_rd_busy, r_rd_err;
  logic [N_RD*R_WIDTH-1:0] w_rdata, r_rd_data;
  // w_wd holds the post-write value of every register, so reads forward for free
  always_comb begin
    w_we = '0;
    w_coll = 1'b0;
    w_wvalid = '0;
    w_busy_next = '0;
    w_rvalid = '0;
    w_rbusy = '0;
    w_rdata = '0;
    for (int r = 0; r < N_REGS; r++) w_wd[r] = r_regs[r];
    for (int i = 0; i < N_WR; i++) begin
      w_wvalid[i] = int'(bus.wr_addr[i*W_ADDR +: W_ADDR]) < N_REGS;
      for (int r = 0; r < N_REGS; r++)
        if (bus.wr_en[i] && w_wvalid[i] && bus.wr_addr[i*W_ADDR +: W_ADDR] == W_ADDR'(r) && !(ZERO_REG != 0 && r == 0)) begin
          w_we[r] = 1'b1;
          w_wd[r] = bus.wr_data[i*R_WIDTH +: R_WIDTH];
        end
      for (int j = 0; j < i; j++)
        if (bus.wr_en[i] && bus.wr_en[j] && w_wvalid[i] && w_wvalid[j] &&
            bus.wr_addr[i*W_ADDR +: W_ADDR] == bus.wr_addr[j*W_ADDR +: W_ADDR])
          w_coll = 1'b1;
    end
    for (int r = 0; r < N_REGS; r++)
      w_busy_next[r] = (r_busy[r] & ~w_we[r]) |
                       (bus.sb_set && bus.sb_addr == W_ADDR'(r) && !(ZERO_REG != 0 && r == 0));
    for (int i = 0; i < N_RD; i++) begin
      w_rvalid[i] = int'(bus.rd_addr[i*W_ADDR +: W_ADDR]) < N_REGS;
      for (int r = 0; r < N_REGS; r++)
        if (bus.rd_addr[i*W_ADDR +: W_ADDR] == W_ADDR'(r)) begin
          w_rdata[i*R_WIDTH +: R_WIDTH] = w_wd[r];
          w_rbusy[i] = w_busy_next[r];
        end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N_REGS; r++) r_regs[r] <= '0;
      r_busy <= '0;
      r_wr_err <= '0;
      r_coll <= 1'b0;
      r_rd_data <= '0;
      r_rd_valid <= '0;
      r_rd_busy <= '0;
      r_rd_err <= '0;
    end else begin
      for (int r = 0; r < N_REGS; r++) if (w_we[r]) r_regs[r] <= w_wd[r];
      r_busy <= w_busy_next;
      r_wr_err <= bus.wr_en & ~w_wvalid;
      r_coll <= w_coll;
      r_rd_valid <= bus.rd_en & w_rvalid;
      r_rd_err <= bus.rd_en & ~w_rvalid;
      for (int i = 0; i < N_RD; i++)
        if (bus.rd_en[i] && w_rvalid[i]) begin
          r_rd_data[i*R_WIDTH +: R_WIDTH] <= w_rdata[i*R_WIDTH +: R_WIDTH];
          r_rd_busy[i] <= w_rbusy[i];
        end
    end
  end
  assign bus.wr_addr_error = r_wr_err;
  assign bus.wr_collision = r_coll;
  assign bus.rd_data = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_busy = r_rd_busy;
  assign bus.rd_addr_error = r_rd_err;
  assign bus.busy_vec = r_busy;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp with 24 registers, 2 write ports, 2 read ports
module tb_regfile_mp;
  localparam int NR = 24, RW = 32, NRD = 2, NWR = 2, ZR = 1, WA = 5;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_err = 0;
  regfile_mp_if #(.N_REGS(NR), .R_WIDTH(RW), .N_RD(NRD), .N_WR(NWR)) bus ();
  regfile_mp #(.N_REGS(NR), .R_WIDTH(RW), .N_RD(NRD), .N_WR(NWR), .ZERO_REG(ZR)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    bus.wr_en = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_en = '0;
    bus.rd_addr = '0;
    bus.sb_set = 1'b0;
    bus.sb_addr = '0;
  endtask
  task automatic wr(input int p, input int a, input logic [31:0] d);
    bus.wr_en[p] = 1'b1;
    bus.wr_addr[p*WA +: WA] = WA'(a);
    bus.wr_data[p*RW +: RW] = d;
  endtask
  task automatic rd(input int p, input int a);
    bus.rd_en[p] = 1'b1;
    bus.rd_addr[p*WA +: WA] = WA'(a);
  endtask
  task automatic sb(input int a);
    bus.sb_set = 1'b1;
    bus.sb_addr = WA'(a);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask
  initial begin
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
    chk("rst_busy_vec", 64'(bus.busy_vec), 64'd0);
    chk("rst_collision", 64'(bus.wr_collision), 64'd0);
    // write r5, read it back on port 1
    wr(0, 5, 32'hDEADBEEF);
    tick();
    chk("w5_collision", 64'(bus.wr_collision), 64'd0);
    chk("w5_addr_err", 64'(bus.wr_addr_error), 64'd0);
    rd(1, 5);
    tick();
    chk("r5_data", 64'(bus.rd_data[RW +: RW]), 64'hDEADBEEF);
    chk("r5_valid", 64'(bus.rd_valid), 64'b10);
    // forwarding: new value wins over stored 0x55
    wr(0, 7, 32'h55);
    tick();
    wr(0, 7, 32'h1234);
    rd(0, 7);
    tick();
    chk("fwd_r7", 64'(bus.rd_data[0 +: RW]), 64'h1234);
    chk("fwd_valid", 64'(bus.rd_valid), 64'b01);
    rd(1, 7);
    tick();
    chk("stored_r7", 64'(bus.rd_data[RW +: RW]), 64'h1234);
    // zero register
    wr(0, 0, 32'hFFFFFFFF);
    sb(0);
    tick();
    chk("r0_busy", 64'(bus.busy_vec), 64'd0);
    rd(0, 0);
    wr(1, 0, 32'hFFFFFFFF);
    tick();
    chk("r0_data", 64'(bus.rd_data[0 +: RW]), 64'd0);
    chk("r0_valid", 64'(bus.rd_valid), 64'b01);
    // two ports to r3: port 1 wins, collision pulses once
    wr(0, 3, 32'hA);
    wr(1, 3, 32'hB);
    tick();
    chk("coll_set", 64'(bus.wr_collision), 64'd1);
    rd(0, 3);
    tick();
    chk("coll_r3", 64'(bus.rd_data[0 +: RW]), 64'hB);
    chk("coll_clear", 64'(bus.wr_collision), 64'd0);
    // scoreboard
    sb(9);
    tick();
    chk("sb9_vec", 64'(bus.busy_vec), 64'h200);
    rd(1, 9);
    tick();
    chk("sb9_rd_busy", 64'(bus.rd_busy), 64'b10);
    wr(0, 9, 32'h77);
    sb(9);
    tick();
    chk("sb9_set_wins", 64'(bus.busy_vec), 64'h200);
    wr(0, 9, 32'h99);
    rd(0, 9);
    tick();
    chk("sb9_cleared", 64'(bus.busy_vec), 64'd0);
    chk("sb9_rd_busy_hold", 64'(bus.rd_busy), 64'b10);
    chk("sb9_fwd", 64'(bus.rd_data[0 +: RW]), 64'h99);
    // out-of-range addresses
    rd(0, 30);
    tick();
    chk("rerr_flag", 64'(bus.rd_addr_error), 64'b01);
    chk("rerr_valid", 64'(bus.rd_valid), 64'd0);
    chk("rerr_hold", 64'(bus.rd_data[0 +: RW]), 64'h99);
    tick();
    chk("rerr_pulse", 64'(bus.rd_addr_error), 64'd0);
    wr(1, 28, 32'hCAFE);
    tick();
    chk("werr_flag", 64'(bus.wr_addr_error), 64'b10);
    chk("werr_busy", 64'(bus.busy_vec), 64'd0);
    rd(0, 5);
    rd(1, 3);
    tick();
    chk("werr_pulse", 64'(bus.wr_addr_error), 64'd0);
    chk("werr_r5", 64'(bus.rd_data[0 +: RW]), 64'hDEADBEEF);
    chk("werr_r3", 64'(bus.rd_data[RW +: RW]), 64'hB);
    // reset overrides activity in the same cycle
    sb(2);
    tick();
    chk("pre_rst_busy", 64'(bus.busy_vec), 64'h4);
    rst = 1'b1;
    wr(0, 5, 32'h1111);
    rd(0, 5);
    rd(1, 30);
    sb(4);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    chk("mid_rst_data", 64'(bus.rd_data), 64'd0);
    chk("mid_rst_valid", 64'(bus.rd_valid), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy_vec), 64'd0);
    chk("mid_rst_rd_busy", 64'(bus.rd_busy), 64'd0);
    chk("mid_rst_rerr", 64'(bus.rd_addr_error), 64'd0);
    rd(0, 5);
    tick();
    chk("post_rst_r5", 64'(bus.rd_data[0 +: RW]), 64'd0);
    chk("post_rst_valid", 64'(bus.rd_valid), 64'b01);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
